// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and tracker state type.
// Used by the tracker RTL and by any bench that needs Gray vectors.
package gray_pkg;

  typedef enum logic [0:0] {
    StInit,
    StTrack
  } track_state_e;

  localparam logic [7:0] ERR_CNT_MAX = 8'd255;

  // Zero-extended operands decode correctly for any word width up to 32.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    logic        acc;
    acc = 1'b0;
    b   = '0;
    for (int i = 31; i >= 0; i--) begin
      acc  = acc ^ g[i];
      b[i] = acc;
    end
    return b;
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/gray_2_bin.sv
// Combinational Gray-to-binary decoder of parameterizable width.
module gray_2_bin #(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] g_i,
  output logic [WIDTH-1:0] b_o
);

  logic acc;

  // Each binary bit is the XOR of all Gray bits at or above it.
  always_comb begin
    acc = 1'b0;
    b_o = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      acc    = acc ^ g_i[i];
      b_o[i] = acc;
    end
  end

endmodule

// File: rtl/gray_2_bin_tracker.sv
// Two-stage Gray decoder that classifies each sample as hold, step up/down or
// illegal jump, and tracks a signed position and a saturating error count.
module gray_2_bin_tracker
  import gray_pkg::*;
#(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned POS_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             g_valid_i,
  input  logic [WIDTH-1:0] g_i,
  input  logic             clr_err_i,
  output logic [WIDTH-1:0] b_o,
  output logic             b_valid_o,
  output logic             step_o,
  output logic             dir_o,
  output logic             err_o,
  output logic [POS_W-1:0] pos_o,
  output logic [7:0]       err_cnt_o
);

  localparam logic [WIDTH-1:0] DeltaUp   = WIDTH'(1);
  localparam logic [WIDTH-1:0] DeltaDown = '1;

  logic [WIDTH-1:0] dec_bin;
  logic [WIDTH-1:0] s1_bin_q;
  logic             s1_valid_q;
  logic [WIDTH-1:0] delta;
  track_state_e     state_q;

  gray_2_bin #(
    .WIDTH(WIDTH)
  ) u_dec (
    .g_i(g_i),
    .b_o(dec_bin)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_valid_q <= 1'b0;
      s1_bin_q   <= '0;
    end else begin
      s1_valid_q <= g_valid_i;
      if (g_valid_i) begin
        s1_bin_q <= dec_bin;
      end
    end
  end

  // Modular difference makes max->0 and 0->max legal single steps.
  assign delta = s1_bin_q - b_o;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= StInit;
      b_o       <= '0;
      b_valid_o <= 1'b0;
      step_o    <= 1'b0;
      dir_o     <= 1'b0;
      err_o     <= 1'b0;
      pos_o     <= '0;
      err_cnt_o <= '0;
    end else begin
      b_valid_o <= s1_valid_q;
      step_o    <= 1'b0;
      err_o     <= 1'b0;
      if (s1_valid_q) begin
        // Every accepted sample becomes the new reference, including resyncs.
        b_o <= s1_bin_q;
        if (state_q == StInit) begin
          state_q <= StTrack;
        end else if (delta == DeltaUp) begin
          step_o <= 1'b1;
          dir_o  <= 1'b1;
          pos_o  <= pos_o + POS_W'(1);
        end else if (delta == DeltaDown) begin
          step_o <= 1'b1;
          dir_o  <= 1'b0;
          pos_o  <= pos_o - POS_W'(1);
        end else if (delta != '0) begin
          err_o <= 1'b1;
          if (err_cnt_o != ERR_CNT_MAX) begin
            err_cnt_o <= err_cnt_o + 8'd1;
          end
        end
      end
      if (clr_err_i) begin
        err_cnt_o <= '0;
      end
    end
  end

endmodule

// File: tb/tb_gray_2_bin_tracker.sv
// Directed bench for gray_2_bin_tracker with hand-computed expected outputs.
module tb_gray_2_bin_tracker;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        g_valid = 1'b0;
  logic [3:0]  g = '0;
  logic        clr_err = 1'b0;
  logic [3:0]  b;
  logic        b_valid, step, dir, err;
  logic [15:0] pos;
  logic [7:0]  err_cnt;
  logic [31:0] obs;

  int n_tests = 0;
  int n_fail  = 0;

  gray_2_bin_tracker #(
    .WIDTH(4),
    .POS_W(16)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .g_valid_i(g_valid),
    .g_i      (g),
    .clr_err_i(clr_err),
    .b_o      (b),
    .b_valid_o(b_valid),
    .step_o   (step),
    .dir_o    (dir),
    .err_o    (err),
    .pos_o    (pos),
    .err_cnt_o(err_cnt)
  );

  always #5 clk = ~clk;

  // Observation word: {b, b_valid, step, dir, err, pos, err_cnt}
  assign obs = {b, b_valid, step, dir, err, pos, err_cnt};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Accept one sample, then wait for its result to appear.
  task automatic sample(input logic [3:0] gv);
    g_valid = 1'b1;
    g       = gv;
    tick();
    g_valid = 1'b0;
    tick();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    g_valid = 1'b1;
    g       = 4'b1111;
    clr_err = 1'b1;
    do_reset();
    g_valid = 1'b0;
    clr_err = 1'b0;
    n_tests++;
    if (obs !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL reset_values got=%h exp=%h", obs, {4'd0, 4'b0, 16'd0, 8'd0});
    end
    // Sample presented during reset must not have entered stage 1.
    tick();
    n_tests++;
    if (b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_drops_input b_valid got=%b exp=0", b_valid);
    end
  endtask

  task automatic test_first_sample();
    sample(4'b0110);
    n_tests++;
    if (obs !== {4'd4, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL first_ref got=%h exp=%h", obs, {4'd4, 4'b1000, 16'd0, 8'd0});
    end
    tick();
    n_tests++;
    if (obs !== {4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL first_ref_bubble got=%h exp=%h", obs, {4'd4, 4'b0000, 16'd0, 8'd0});
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  gv  [3] = '{4'b0111, 4'b0101, 4'b0111};
    logic [3:0]  eb  [3] = '{4'd5, 4'd6, 4'd5};
    logic        ed  [3] = '{1'b1, 1'b1, 1'b0};
    logic [15:0] ep  [3] = '{16'd1, 16'd2, 16'd1};
    for (int i = 0; i < 4; i++) begin
      g_valid = (i < 3);
      if (i < 3) g = gv[i];
      tick();
      if (i >= 1) begin
        n_tests++;
        if (obs !== {eb[i-1], 1'b1, 1'b1, ed[i-1], 1'b0, ep[i-1], 8'd0}) begin
          n_fail++;
          $display("FAIL step_%0d got=%h exp=%h", i - 1, obs,
                   {eb[i-1], 1'b1, 1'b1, ed[i-1], 1'b0, ep[i-1], 8'd0});
        end
      end
    end
    tick();
    n_tests++;
    if (obs !== {4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 16'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL step_hold got=%h exp=%h", obs, {4'd5, 4'b0000, 16'd1, 8'd0});
    end
    // Same code again: hold, valid but no step.
    sample(4'b0111);
    n_tests++;
    if (obs !== {4'd5, 1'b1, 1'b0, 1'b0, 1'b0, 16'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL hold_delta0 got=%h exp=%h", obs, {4'd5, 4'b1000, 16'd1, 8'd0});
    end
  endtask

  task automatic test_wrap();
    do_reset();
    sample(4'b1000);
    n_tests++;
    if (obs !== {4'd15, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL wrap_ref got=%h exp=%h", obs, {4'd15, 4'b1000, 16'd0, 8'd0});
    end
    sample(4'b0000);
    n_tests++;
    if (obs !== {4'd0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd1, 8'd0}) begin
      n_fail++;
      $display("FAIL wrap_up got=%h exp=%h", obs, {4'd0, 4'b1110, 16'd1, 8'd0});
    end
    sample(4'b1000);
    n_tests++;
    if (obs !== {4'd15, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL wrap_down got=%h exp=%h", obs, {4'd15, 4'b1100, 16'd0, 8'd0});
    end
  endtask

  task automatic test_illegal();
    sample(4'b0000);  // 15 -> 0, up step, pos 1
    sample(4'b0011);  // 0 -> 2, illegal
    n_tests++;
    if (obs !== {4'd2, 1'b1, 1'b0, 1'b1, 1'b1, 16'd1, 8'd1}) begin
      n_fail++;
      $display("FAIL illegal_jump got=%h exp=%h", obs, {4'd2, 4'b1011, 16'd1, 8'd1});
    end
    tick();
    n_tests++;
    if (err !== 1'b0) begin
      n_fail++;
      $display("FAIL illegal_pulse err got=%b exp=0", err);
    end
    sample(4'b0010);  // 2 -> 3 after resync
    n_tests++;
    if (obs !== {4'd3, 1'b1, 1'b1, 1'b1, 1'b0, 16'd2, 8'd1}) begin
      n_fail++;
      $display("FAIL resync_step got=%h exp=%h", obs, {4'd3, 4'b1110, 16'd2, 8'd1});
    end
  endtask

  task automatic test_saturate_clear();
    // 300 back-to-back jumps between 8 and 0, each one illegal.
    for (int i = 0; i < 300; i++) begin
      g_valid = 1'b1;
      g       = (i % 2 == 0) ? 4'b1100 : 4'b0000;
      tick();
    end
    g_valid = 1'b0;
    tick();
    n_tests++;
    if (obs !== {4'd0, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 8'd255}) begin
      n_fail++;
      $display("FAIL err_saturate got=%h exp=%h", obs, {4'd0, 4'b1011, 16'd2, 8'd255});
    end
    g_valid = 1'b1;
    g       = 4'b1100;
    tick();
    g_valid = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    n_tests++;
    if (obs !== {4'd8, 1'b1, 1'b0, 1'b1, 1'b1, 16'd2, 8'd0}) begin
      n_fail++;
      $display("FAIL clr_priority got=%h exp=%h", obs, {4'd8, 4'b1011, 16'd2, 8'd0});
    end
  endtask

  task automatic test_reset_midflight();
    g_valid = 1'b1;
    g       = 4'b0001;
    tick();  // sample now in stage 1
    g_valid = 1'b0;
    rst     = 1'b1;
    tick();
    rst = 1'b0;
    n_tests++;
    if (obs !== {4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL midflight_reset got=%h exp=%h", obs, 32'h0);
    end
    tick();
    n_tests++;
    if (b_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL midflight_drop b_valid got=%b exp=0", b_valid);
    end
    sample(4'b1100);
    n_tests++;
    if (obs !== {4'd8, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0, 8'd0}) begin
      n_fail++;
      $display("FAIL post_reset_ref got=%h exp=%h", obs, {4'd8, 4'b1000, 16'd0, 8'd0});
    end
    sample(4'b0100);  // 8 -> 7, pos goes negative
    n_tests++;
    if (obs !== {4'd7, 1'b1, 1'b1, 1'b0, 1'b0, 16'hffff, 8'd0}) begin
      n_fail++;
      $display("FAIL pos_negative got=%h exp=%h", obs, {4'd7, 4'b1100, 16'hffff, 8'd0});
    end
  endtask

  initial begin
    test_reset();
    test_first_sample();
    test_back_to_back();
    test_wrap();
    test_illegal();
    test_saturate_clear();
    test_reset_midflight();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
